// File: rtl/data_bus_bridge_pkg.sv
// bridge_pkg: shared state type and constants for the data bus bridge
package bridge_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE} bridge_state_t;
    localparam logic [63:0] RD_ERR_FILL = '1;
endpackage

// File: rtl/data_bus_bridge_if.sv
// data_bus_bridge_if: req/ack bus between the bridge and the slow data slave
interface data_bus_bridge_if #(
    parameter int Dbits = 32,
    parameter int Abits = 10
);
    logic             bus_req;
    logic             bus_we;
    logic [Abits-1:0] bus_addr;
    logic [Dbits-1:0] bus_wdata;
    logic             bus_ack;
    logic [Dbits-1:0] bus_rdata;
    modport master (output bus_req, bus_we, bus_addr, bus_wdata, input bus_ack, bus_rdata);
    modport slave (input bus_req, bus_we, bus_addr, bus_wdata, output bus_ack, bus_rdata);
endinterface

// File: rtl/data_bus_bridge_bus_timeout_counter.sv
// bus_timeout_counter: counts REQ cycles and flags the last cycle before abort
module bus_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT);
    logic [W-1:0] cnt_q, cnt_d;
    // clear has priority so a completed transaction never leaves a stale count
    always_comb cnt_d = clr ? '0 : inc ? cnt_q + W'(1) : cnt_q;
    // count register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign expired = cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: stalls the CPU while a load/store runs a req/ack transaction to a slow slave
module data_bus_bridge
    import bridge_pkg::*;
#(
    parameter int Dbits   = 32,
    parameter int Abits   = 10,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic [Dbits-1:0] mem_addr,
    input  logic [Dbits-1:0] mem_writedata,
    output logic [Dbits-1:0] mem_readdata,
    output logic             enable,
    output logic             bus_error,
    input  logic             err_clear,
    data_bus_bridge_if.master bus
);
    bridge_state_t    state_q, state_d;
    logic             req_q, req_d, we_q, we_d, err_q, err_d;
    logic [Abits-1:0] addr_q, addr_d;
    logic [Dbits-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic             access, aligned, expired;
    logic             unused_addr_bits;

    assign access  = mem_rd | mem_wr;
    assign aligned = mem_addr[1:0] == 2'b00;
    assign unused_addr_bits = ^mem_addr[Dbits-1:Abits+2];

    bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q != REQ || bus.bus_ack),
        .inc     (state_q == REQ),
        .expired (expired)
    );

    // next-state, bus latches, read data and sticky error (a new error beats err_clear)
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q & ~err_clear;
        case (state_q)
            IDLE: begin
                if (access && aligned) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = mem_wr;
                    addr_d  = mem_addr[Abits+1:2];
                    wdata_d = mem_writedata;
                end else if (access) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            REQ: begin
                if (bus.bus_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    rdata_d = we_q ? rdata_q : bus.bus_rdata;
                end else if (expired) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = Dbits'(RD_ERR_FILL);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and latch registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign enable        = !reset && (state_q == IDLE ? !access : state_q == DONE);
    assign mem_readdata  = rdata_q;
    assign bus_error     = err_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
endmodule
